// File: rtl/csma_tx_scheduler_if.sv
// csma_tx_scheduler_if: signal bundle between the transmit queue, backoff
// generator and TX chain (master side) and the CSMA scheduler (slave side).
// Ports: strobe, data_waiting, carrier_present, burst_done, ack_ok flow
// master->slave; run_tx, run_rx, max_backoff, tx_go, pkt_sent, pkt_dropped,
// retry_count flow slave->master.
interface csma_tx_scheduler_if;
    logic        strobe;
    logic        data_waiting;
    logic        carrier_present;
    logic        burst_done;
    logic        ack_ok;
    logic        run_tx;
    logic        run_rx;
    logic [31:0] max_backoff;
    logic        tx_go;
    logic        pkt_sent;
    logic        pkt_dropped;
    logic [3:0]  retry_count;

    modport master (
        output strobe, data_waiting, carrier_present, burst_done, ack_ok,
        input  run_tx, run_rx, max_backoff, tx_go, pkt_sent, pkt_dropped,
        input  retry_count
    );

    modport slave (
        input  strobe, data_waiting, carrier_present, burst_done, ack_ok,
        output run_tx, run_rx, max_backoff, tx_go, pkt_sent, pkt_dropped,
        output retry_count
    );
endinterface

// File: rtl/csma_tx_scheduler.sv
// csma_tx_scheduler: CSMA transmit sequencer. Defers until DIFS_STROBES
// consecutive carrier-clear strobes, runs the TX chain for one burst, then
// (with CSMA_TX_SCHED_ACK_EN defined) waits for an acknowledge and retries
// with binary-exponential contention-window growth.
// Ports: clk, rst (sync, active-high), bus (csma_tx_scheduler_if.slave).
// Optional feature macro: CSMA_TX_SCHED_ACK_EN (undefined = no ACK/retry).
module csma_tx_scheduler #(
    parameter logic [31:0] CW_MIN       = 32'h0000000F,
    parameter logic [31:0] CW_MAX       = 32'h000003FF,
    parameter int          MAX_RETRIES  = 7,
    parameter int          DIFS_STROBES = 16,
    parameter int          ACK_TIMEOUT  = 1024
) (
    input logic                 clk,
    input logic                 rst,
    csma_tx_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEFER    = 2'd1,
        TX       = 2'd2,
        WAIT_ACK = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] idle_cnt_q, idle_cnt_d;
    logic [3:0]  retry_q, retry_d;
    logic [31:0] cw_q, cw_d;
    logic        tx_go_q, tx_go_d;
    logic        sent_q, sent_d;
    logic        drop_q, drop_d;
    logic        run_tx_q, run_rx_q;

`ifdef CSMA_TX_SCHED_ACK_EN
    logic [31:0] ack_timer_q, ack_timer_d;
    logic [32:0] cw_grow;
    logic [31:0] cw_up;

    // One extra bit so the doubled window cannot wrap before saturation.
    assign cw_grow = {cw_q, 1'b1};
    assign cw_up   = (cw_grow > {1'b0, CW_MAX}) ? CW_MAX : cw_grow[31:0];
`else
    logic unused_cfg;

    assign unused_cfg = ^{CW_MAX, 32'(MAX_RETRIES),
                          32'(ACK_TIMEOUT), bus.ack_ok};
`endif

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        retry_d    = retry_q;
        cw_d       = cw_q;
        tx_go_d    = 1'b0;
        sent_d     = 1'b0;
        drop_d     = 1'b0;
`ifdef CSMA_TX_SCHED_ACK_EN
        ack_timer_d = ack_timer_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.data_waiting) begin
                    state_d    = DEFER;
                    idle_cnt_d = '0;
                end
            end
            DEFER: begin
                if (!bus.data_waiting) begin
                    state_d = IDLE;
                end else if (bus.strobe) begin
                    if (bus.carrier_present) begin
                        idle_cnt_d = '0;
                    end else if (idle_cnt_q == 32'(DIFS_STROBES - 1)) begin
                        state_d    = TX;
                        tx_go_d    = 1'b1;
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 32'd1;
                    end
                end
            end
            TX: begin
                if (bus.burst_done) begin
`ifdef CSMA_TX_SCHED_ACK_EN
                    state_d     = WAIT_ACK;
                    ack_timer_d = '0;
`else
                    state_d = IDLE;
                    sent_d  = 1'b1;
`endif
                end
            end
            WAIT_ACK: begin
`ifdef CSMA_TX_SCHED_ACK_EN
                // ack_ok is tested first so it wins over a same-cycle timeout.
                if (bus.ack_ok) begin
                    state_d = IDLE;
                    sent_d  = 1'b1;
                    retry_d = '0;
                    cw_d    = CW_MIN;
                end else if (bus.strobe) begin
                    if (ack_timer_q == 32'(ACK_TIMEOUT - 1)) begin
                        if (retry_q == 4'(MAX_RETRIES)) begin
                            state_d = IDLE;
                            drop_d  = 1'b1;
                            retry_d = '0;
                            cw_d    = CW_MIN;
                        end else begin
                            state_d    = DEFER;
                            idle_cnt_d = '0;
                            retry_d    = retry_q + 4'd1;
                            cw_d       = cw_up;
                        end
                    end else begin
                        ack_timer_d = ack_timer_q + 32'd1;
                    end
                end
`else
                state_d = IDLE;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idle_cnt_q <= '0;
            retry_q    <= '0;
            cw_q       <= CW_MIN;
            tx_go_q    <= 1'b0;
            sent_q     <= 1'b0;
            drop_q     <= 1'b0;
            run_tx_q   <= 1'b0;
            run_rx_q   <= 1'b1;
`ifdef CSMA_TX_SCHED_ACK_EN
            ack_timer_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            retry_q    <= retry_d;
            cw_q       <= cw_d;
            tx_go_q    <= tx_go_d;
            sent_q     <= sent_d;
            drop_q     <= drop_d;
            run_tx_q   <= (state_d == TX);
            run_rx_q   <= (state_d != TX);
`ifdef CSMA_TX_SCHED_ACK_EN
            ack_timer_q <= ack_timer_d;
`endif
        end
    end

    assign bus.run_tx      = run_tx_q;
    assign bus.run_rx      = run_rx_q;
    assign bus.max_backoff = cw_q;
    assign bus.tx_go       = tx_go_q;
    assign bus.pkt_sent    = sent_q;
    assign bus.pkt_dropped = drop_q;
    assign bus.retry_count = retry_q;

endmodule
